// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: owns PC, IR, A, B and flags.
// Optional HALT_ON_OVF_EN: EXEC overflow halts the core and raises a sticky ovf_trap output.
module cpu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_in_A,
    output logic [DATA_WIDTH-1:0] alu_in_B,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_overflow,
    input  logic                  alu_zero,
    input  logic                  alu_negative,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [2:0]            flags,
    output logic                  halted
`ifdef HALT_ON_OVF_EN
    ,
    output logic                  ovf_trap
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_HALT     = 4'b0000,
        OP_LOAD_B   = 4'b0001,
        OP_LOAD_A   = 4'b0010,
        OP_STORE_A  = 4'b0100,
        OP_ADD      = 4'b1000,
        OP_SUB      = 4'b1001,
        OP_JUMP     = 4'b1010,
        OP_JUMP_NEG = 4'b1011
    } opcode_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;

    assign opcode     = ir[DATA_WIDTH-1 -: 4];
    assign operand    = ir[ADDR_WIDTH-1:0];
    assign alu_opcode = opcode;
    assign alu_in_A   = reg_a;
    assign alu_in_B   = reg_b;
    assign mem_wdata  = reg_a;

    // Request lines come from state and IR only, so they hold steady across a stall.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc;
        case (state)
            S_FETCH: mem_rd = 1'b1;
            S_MEM: begin
                mem_addr = operand;
                if (opcode == OP_STORE_A) mem_wr = 1'b1;
                else                      mem_rd = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            flags    <= '0;
            halted   <= 1'b0;
`ifdef HALT_ON_OVF_EN
            ovf_trap <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_WIDTH'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_HALT: begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end
                        OP_LOAD_A, OP_LOAD_B, OP_STORE_A: state <= S_MEM;
                        OP_ADD, OP_SUB:                   state <= S_EXEC;
                        OP_JUMP: begin
                            pc    <= operand;
                            state <= S_FETCH;
                        end
                        OP_JUMP_NEG: begin
                            if (flags[0]) pc <= operand;
                            state <= S_FETCH;
                        end
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opcode == OP_LOAD_A) reg_a <= mem_rdata;
                        if (opcode == OP_LOAD_B) reg_b <= mem_rdata;
                        state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    reg_a <= alu_out;
                    flags <= {alu_overflow, alu_zero, alu_negative};
`ifdef HALT_ON_OVF_EN
                    if (alu_overflow) begin
                        state    <= S_HALTED;
                        halted   <= 1'b1;
                        ovf_trap <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
`else
                    state <= S_FETCH;
`endif
                end
                S_HALTED: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural memory and ALU around the DUT,
// hand-computed expectations checked with immediate assertions.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b1;
    logic [3:0] alu_opcode;
    logic [7:0] alu_in_A;
    logic [7:0] alu_in_B;
    logic [7:0] alu_out;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_negative;
    logic [3:0] pc;
    logic [2:0] flags;
    logic       halted;
`ifdef HALT_ON_OVF_EN
    logic       ovf_trap;
`endif

    logic [7:0] mem [16];
    int         wr_count = 0;
    int         checks = 0;
    int         fails = 0;
    int         cyc;
    int         base;

    cpu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_opcode(alu_opcode), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .pc(pc), .flags(flags), .halted(halted)
`ifdef HALT_ON_OVF_EN
        , .ovf_trap(ovf_trap)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst_n && mem_wr && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    // Reference ALU; a recognisable junk value for non-arithmetic opcodes exposes stray captures.
    always_comb begin
        logic [7:0] r;
        r            = 8'hEE;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        alu_negative = 1'b0;
        if (alu_opcode == 4'b1000) begin
            r            = alu_in_A + alu_in_B;
            alu_overflow = (alu_in_A[7] == alu_in_B[7]) && (r[7] != alu_in_A[7]);
        end else if (alu_opcode == 4'b1001) begin
            r            = alu_in_A - alu_in_B;
            alu_overflow = (alu_in_A[7] != alu_in_B[7]) && (r[7] != alu_in_A[7]);
        end
        if (alu_opcode == 4'b1000 || alu_opcode == 4'b1001) begin
            alu_zero     = (r == 8'h00);
            alu_negative = r[7];
        end
        alu_out = r;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        @(negedge clk);
    endtask

    task automatic release_reset(input logic ready);
        mem_ready = ready;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 200) begin
            tick();
            cycles++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic wait_store();
        for (int i = 0; i < 20 && !mem_wr; i++) tick();
        check("store_seen", mem_wr, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and HALT-at-0 timing
        hold_reset();
        check("rst_pc", pc, 4'h0);
        check("rst_flags", flags, 3'b000);
        check("rst_ab", {alu_in_A, alu_in_B}, 16'h0000);
        check("rst_ir", alu_opcode, 4'h0);
        check("rst_req", {mem_rd, mem_wr, halted}, 3'b000);
        release_reset(1'b1);
        check("idle_no_req", mem_rd, 1'b0);
        tick();
        check("fetch_req", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 4'h0});
        tick();
        check("decode_not_halted", halted, 1'b0);
        tick();
        check("halted_3cyc", halted, 1'b1);
        check("halt_pc", pc, 4'h1);
        tick();
        check("halted_frozen", {halted, pc, mem_rd, mem_wr}, {1'b1, 4'h1, 2'b00});

        // LOAD_A E, LOAD_B F, ADD, STORE_A D, HALT
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h1F; mem[2] <= 8'h80; mem[3] <= 8'h4D; mem[4] <= 8'h00;
        mem[14] <= 8'h05; mem[15] <= 8'h03;
        release_reset(1'b1);
        run_to_halt(cyc);
        check("add_cycles", cyc, 15);
        check("add_store", mem[13], 8'h08);
        check("add_a", alu_in_A, 8'h08);
        check("add_b", alu_in_B, 8'h03);
        check("add_flags", flags, 3'b000);
        check("add_pc", pc, 4'h5);

        // ADD overflow 0x7F + 0x01
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h1F; mem[2] <= 8'h80; mem[3] <= 8'h00;
        mem[14] <= 8'h7F; mem[15] <= 8'h01;
        release_reset(1'b1);
        run_to_halt(cyc);
        check("ovf_a", alu_in_A, 8'h80);
        check("ovf_flags", flags, 3'b101);
`ifdef HALT_ON_OVF_EN
        check("ovf_cycles", cyc, 10);
        check("ovf_trap", ovf_trap, 1'b1);
        check("ovf_pc", pc, 4'h3);
`else
        check("ovf_cycles", cyc, 12);
        check("ovf_pc", pc, 4'h4);
`endif

        // SUB 3-3 then JUMP_NEG 9 not taken
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h1F; mem[2] <= 8'h90; mem[3] <= 8'hB9; mem[4] <= 8'h00;
        mem[14] <= 8'h03; mem[15] <= 8'h03;
        release_reset(1'b1);
        run_to_halt(cyc);
        check("sub0_cycles", cyc, 14);
        check("sub0_a", alu_in_A, 8'h00);
        check("sub0_flags", flags, 3'b010);
        check("jn_not_taken_pc", pc, 4'h5);

        // SUB 1-2 then JUMP_NEG 9 taken
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h1F; mem[2] <= 8'h90; mem[3] <= 8'hB9; mem[4] <= 8'h00;
        mem[14] <= 8'h01; mem[15] <= 8'h02;
        release_reset(1'b1);
        run_to_halt(cyc);
        check("subn_a", alu_in_A, 8'hFF);
        check("subn_flags", flags, 3'b001);
        check("jn_taken_pc", pc, 4'hA);

        // Stalls in FETCH and in STORE_A
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h4D; mem[2] <= 8'h00; mem[14] <= 8'h5A;
        release_reset(1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("fetch_stall", {mem_rd, mem_wr, mem_addr, mem_wdata, pc},
                  {1'b1, 1'b0, 4'h0, 8'h00, 4'h0});
            tick();
        end
        mem_ready = 1'b1;
        wait_store();
        mem_ready = 1'b0;
        base = wr_count;
        for (int i = 0; i < 4; i++) begin
            check("store_stall", {mem_rd, mem_wr, mem_addr, mem_wdata},
                  {1'b0, 1'b1, 4'hD, 8'h5A});
            tick();
        end
        check("no_write_while_stalled", wr_count - base, 0);
        mem_ready = 1'b1;
        run_to_halt(cyc);
        check("stall_store_data", mem[13], 8'h5A);
        check("one_write", wr_count - base, 1);

        // Reset pulsed during a stalled store
        hold_reset();
        mem[0] <= 8'h2E; mem[1] <= 8'h4D; mem[2] <= 8'h00; mem[14] <= 8'h5A;
        release_reset(1'b1);
        wait_store();
        mem_ready = 1'b0;
        base = wr_count;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_regs", {pc, flags, alu_in_A, alu_in_B, alu_opcode},
              {4'h0, 3'b000, 8'h00, 8'h00, 4'h0});
        check("midrst_req", {mem_rd, mem_wr, halted}, 3'b000);
        mem_ready = 1'b1;
        tick();
        check("midrst_no_write", {wr_count - base, 24'h0, mem[13]}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("midrst_idle", mem_rd, 1'b0);
        tick();
        check("midrst_refetch", {mem_rd, mem_addr}, {1'b1, 4'h0});

        // JUMP F, NOP at F, PC wraps to 0
        hold_reset();
        mem[0] <= 8'hAF; mem[15] <= 8'hC0;
        release_reset(1'b1);
        tick();
        tick();
        check("jmp_decode_pc", pc, 4'h1);
        tick();
        check("jmp_target_fetch", {mem_rd, mem_addr, pc}, {1'b1, 4'hF, 4'hF});
        tick();
        check("pc_wrap", pc, 4'h0);
        tick();
        check("wrap_fetch", {mem_rd, mem_addr}, {1'b1, 4'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
